// File: rtl/capture_push_arbiter_if.sv
// Capture-side bundle of the push arbiter: per-source capture pulses in, FIFO push and status out.
// The capture decoders drive through master; the arbiter sits on slave.
interface capture_push_arbiter_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned DW    = 24,
    parameter int unsigned CNT_W = 16
) ();
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC*DW-1:0] src_data;
    logic                full;
    logic                drop_clr;
    logic                push_s;
    logic [DW-1:0]       push_dt;
    logic [N_SRC-1:0]    pending;
    logic                busy;
    logic [CNT_W-1:0]    drop_cnt;

    modport master (
        output src_valid, src_data, full, drop_clr,
        input  push_s, push_dt, pending, busy, drop_cnt
    );

    modport slave (
        input  src_valid, src_data, full, drop_clr,
        output push_s, push_dt, pending, busy, drop_cnt
    );
endinterface

// File: rtl/capture_push_arbiter.sv
// Shares the capture FIFO push port among unstallable bus-capture sources, each with a
// one-deep holding register, issuing a push pulse followed by one gap cycle.
module capture_push_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned DW    = 24,
    parameter int unsigned CNT_W = 16,
    parameter bit          PRIO0 = 1'b1
) (
    input logic clk,
    input logic reset,
    capture_push_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {StIdle, StPush, StGap} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] hold_v_q, hold_v_d;
    logic [DW-1:0]    hold_d_q [N_SRC];
    logic [N_SRC-1:0] take;
    logic [N_SRC-1:0] drop_vec;
    logic             push_s_q, push_s_d;
    logic [DW-1:0]    push_dt_q, push_dt_d;
    logic [IDX_W-1:0] rr_last_q, rr_last_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             grant_en;
    logic             prio_hit;
    logic             found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] idx;
    logic [N_SRC-1:0] grant_vec;
    logic [CNT_W:0]   n_drop;
    logic [CNT_W:0]   sum;

    // Grant selection: optional fixed priority for the frame marker, else round-robin.
    always_comb begin
        grant_en  = (state_q == StIdle) && !bus.full && (|hold_v_q);
        prio_hit  = PRIO0 && hold_v_q[0];
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        if (!prio_hit) begin
            for (int unsigned k = 1; k <= N_SRC; k++) begin
                idx = IDX_W'((32'(rr_last_q) + k) % N_SRC);
                if (!found && hold_v_q[idx] && !(PRIO0 && (idx == '0))) begin
                    found     = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        grant_vec = grant_en ? (N_SRC'(1) << grant_idx) : '0;
    end

    // A granted source frees its register at the same edge, so a new pulse there is kept.
    always_comb begin
        take     = '0;
        drop_vec = '0;
        hold_v_d = hold_v_q;
        n_drop   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            take[i]     = bus.src_valid[i] && (!hold_v_q[i] || grant_vec[i]);
            drop_vec[i] = bus.src_valid[i] && !take[i];
            if (take[i]) begin
                hold_v_d[i] = 1'b1;
            end else if (grant_vec[i]) begin
                hold_v_d[i] = 1'b0;
            end
            n_drop = n_drop + {{CNT_W{1'b0}}, drop_vec[i]};
        end
        sum = {1'b0, drop_cnt_q} + n_drop;
        if (bus.drop_clr) begin
            drop_cnt_d = n_drop[CNT_W-1:0];
        end else if (sum[CNT_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = sum[CNT_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        push_s_d  = 1'b0;
        push_dt_d = push_dt_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            StIdle: begin
                if (grant_en) begin
                    state_d   = StPush;
                    push_s_d  = 1'b1;
                    push_dt_d = hold_d_q[grant_idx];
                    if (!prio_hit) begin
                        rr_last_d = grant_idx;
                    end
                end
            end
            StPush:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            hold_v_q   <= '0;
            push_s_q   <= 1'b0;
            push_dt_q  <= '0;
            rr_last_q  <= IDX_W'(N_SRC - 1);
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_v_q   <= hold_v_d;
            push_s_q   <= push_s_d;
            push_dt_q  <= push_dt_d;
            rr_last_q  <= rr_last_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Held words need no reset: hold_v qualifies them.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (take[i]) begin
                hold_d_q[i] <= bus.src_data[i*DW +: DW];
            end
        end
    end

    assign bus.push_s   = push_s_q;
    assign bus.push_dt  = push_dt_q;
    assign bus.pending  = hold_v_q;
    assign bus.drop_cnt = drop_cnt_q;
    assign bus.busy     = (state_q != StIdle) || (|hold_v_q);

endmodule

// File: tb/tb_capture_push_arbiter.sv
// Scoreboard bench: tasks queue expected pushes when driving sources; a monitor collects
// observed pushes with their cycle stamps and each task compares them inline.
module tb_capture_push_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    capture_push_arbiter_if #(.N_SRC(4), .DW(24), .CNT_W(16)) ifa ();
    capture_push_arbiter_if #(.N_SRC(4), .DW(24), .CNT_W(16)) ifb ();

    capture_push_arbiter #(.N_SRC(4), .DW(24), .CNT_W(16), .PRIO0(1'b1)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ifa.slave)
    );

    capture_push_arbiter #(.N_SRC(4), .DW(24), .CNT_W(16), .PRIO0(1'b0)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ifb.slave)
    );

    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    logic [23:0] obs_a_w[$];
    int          obs_a_t[$];
    logic [23:0] obs_b_w[$];
    int          obs_b_t[$];

    always @(negedge clk) begin
        if (ifa.push_s) begin
            obs_a_w.push_back(ifa.push_dt);
            obs_a_t.push_back(cyc);
        end
        if (ifb.push_s) begin
            obs_b_w.push_back(ifb.push_dt);
            obs_b_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_a(input int s, input logic [23:0] w);
        ifa.src_valid[s]          = 1'b1;
        ifa.src_data[s*24 +: 24]  = w;
    endtask

    task automatic do_reset();
        ifa.src_valid = '0; ifa.src_data = '0; ifa.full = 1'b0; ifa.drop_clr = 1'b0;
        ifb.src_valid = '0; ifb.src_data = '0; ifb.full = 1'b0; ifb.drop_clr = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_a.delete(); exp_b.delete();
        obs_a_w.delete(); obs_a_t.delete(); obs_b_w.delete(); obs_b_t.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (ifa.push_s !== 1'b0) $display("FAIL reset_push_s: got %b want 0", ifa.push_s); else n_pass++;
        n_chk++; if (ifa.push_dt !== 24'h0) $display("FAIL reset_push_dt: got %h want 000000", ifa.push_dt); else n_pass++;
        n_chk++; if (ifa.pending !== 4'h0) $display("FAIL reset_pending: got %h want 0", ifa.pending); else n_pass++;
        n_chk++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifa.busy); else n_pass++;
        n_chk++; if (ifa.drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt: got %h want 0000", ifa.drop_cnt); else n_pass++;
    endtask

    task automatic test_single();
        int c;
        do_reset();
        c = cyc;
        exp_a.push_back(24'h037F12);
        drive_a(2, 24'h037F12);
        tick();
        ifa.src_valid = '0;
        n_chk++; if (ifa.pending !== 4'b0100) $display("FAIL single_pending: got %b want 0100", ifa.pending); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cyc == c + 3) begin
                n_chk++; if (ifa.busy !== 1'b1) $display("FAIL single_busy_gap: got %b want 1", ifa.busy); else n_pass++;
            end
            if (cyc == c + 4) begin
                n_chk++; if (ifa.busy !== 1'b0) $display("FAIL single_busy_idle: got %b want 0", ifa.busy); else n_pass++;
            end
        end
        n_chk++; if (obs_a_w.size() !== 1) $display("FAIL single_push_count: got %0d want 1", obs_a_w.size()); else n_pass++;
        while (obs_a_w.size() > 0 && exp_a.size() > 0) begin
            logic [23:0] w, e;
            int t;
            w = obs_a_w.pop_front(); t = obs_a_t.pop_front(); e = exp_a.pop_front();
            n_chk++; if (w !== e) $display("FAIL single_word: got %h want %h", w, e); else n_pass++;
            n_chk++; if (t !== c + 2) $display("FAIL single_latency: got cycle %0d want %0d", t, c + 2); else n_pass++;
        end
        n_chk++; if (ifa.drop_cnt !== 16'h0) $display("FAIL single_drop_cnt: got %h want 0000", ifa.drop_cnt); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int c;
        logic [23:0] words [4];
        words[0] = 24'h800001; words[1] = 24'h080011; words[2] = 24'h030022; words[3] = 24'h040033;
        do_reset();
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            drive_a(i, words[i]);
            exp_a.push_back(words[i]);
        end
        tick();
        ifa.src_valid = '0;
        for (int k = 0; k < 14; k++) tick();
        n_chk++; if (obs_a_w.size() !== 4) $display("FAIL simul_push_count: got %0d want 4", obs_a_w.size()); else n_pass++;
        for (int i = 0; i < 4 && obs_a_w.size() > 0 && exp_a.size() > 0; i++) begin
            logic [23:0] w, e;
            int t;
            w = obs_a_w.pop_front(); t = obs_a_t.pop_front(); e = exp_a.pop_front();
            n_chk++; if (w !== e) $display("FAIL simul_word%0d: got %h want %h", i, w, e); else n_pass++;
            n_chk++; if (t !== c + 2 + 3 * i) $display("FAIL simul_time%0d: got %0d want %0d", i, t, c + 2 + 3 * i); else n_pass++;
        end
        n_chk++; if (ifa.drop_cnt !== 16'h0) $display("FAIL simul_drop_cnt: got %h want 0000", ifa.drop_cnt); else n_pass++;
    endtask

    task automatic test_round_robin();
        int pulses [4];
        int got [4];
        int s;
        bit done;
        logic [23:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) begin pulses[i] = 0; got[i] = 0; end
        foreach (pulses[i]) pulses[i] = 0;
        for (int i = 1; i < 4; i += 2) begin
            w = {8'(i), 8'h5A, 8'(pulses[i])};
            ifb.src_valid[i] = 1'b1; ifb.src_data[i*24 +: 24] = w;
            exp_b.push_back(w);
            pulses[i]++;
        end
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            ifb.src_valid = '0;
            if (ifb.push_s) begin
                s = int'(ifb.push_dt[23:16]);
                if ((s == 1 || s == 3) && pulses[s] < 10) begin
                    w = {8'(s), 8'h5A, 8'(pulses[s])};
                    ifb.src_valid[s] = 1'b1; ifb.src_data[s*24 +: 24] = w;
                    exp_b.push_back(w);
                    pulses[s]++;
                end
            end
            if (obs_b_w.size() >= 20 && !ifb.busy) done = 1'b1;
        end
        n_chk++; if (!done) $display("FAIL rr_timeout: got %0d pushes want 20 within 300 cycles", obs_b_w.size()); else n_pass++;
        n_chk++; if (obs_b_w.size() !== 20) $display("FAIL rr_push_count: got %0d want 20", obs_b_w.size()); else n_pass++;
        while (obs_b_w.size() > 0 && exp_b.size() > 0) begin
            logic [23:0] o, e;
            o = obs_b_w.pop_front(); void'(obs_b_t.pop_front()); e = exp_b.pop_front();
            n_chk++; if (o !== e) $display("FAIL rr_word: got %h want %h", o, e); else n_pass++;
            if (o[23:16] < 4) got[o[23:16]]++;
        end
        n_chk++; if (got[1] !== 10) $display("FAIL rr_src1_count: got %0d want 10", got[1]); else n_pass++;
        n_chk++; if (got[3] !== 10) $display("FAIL rr_src3_count: got %0d want 10", got[3]); else n_pass++;
    endtask

    task automatic test_overrun();
        do_reset();
        ifa.full = 1'b1;
        exp_a.push_back(24'h3A0001);
        drive_a(3, 24'h3A0001); tick();
        drive_a(3, 24'h3A0002); tick();
        drive_a(3, 24'h3A0003); tick();
        ifa.src_valid = '0;
        n_chk++; if (ifa.pending !== 4'b1000) $display("FAIL ovr_pending: got %b want 1000", ifa.pending); else n_pass++;
        n_chk++; if (ifa.drop_cnt !== 16'd2) $display("FAIL ovr_drop_cnt: got %0d want 2", ifa.drop_cnt); else n_pass++;
        for (int k = 0; k < 4; k++) tick();
        n_chk++; if (obs_a_w.size() !== 0) $display("FAIL ovr_push_while_full: got %0d pushes want 0", obs_a_w.size()); else n_pass++;
        ifa.full = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        n_chk++; if (obs_a_w.size() !== 1) $display("FAIL ovr_push_count: got %0d want 1", obs_a_w.size()); else n_pass++;
        while (obs_a_w.size() > 0 && exp_a.size() > 0) begin
            logic [23:0] o, e;
            o = obs_a_w.pop_front(); void'(obs_a_t.pop_front()); e = exp_a.pop_front();
            n_chk++; if (o !== e) $display("FAIL ovr_word: got %h want %h", o, e); else n_pass++;
        end
        n_chk++; if (ifa.pending !== 4'b0000) $display("FAIL ovr_pending_after: got %b want 0000", ifa.pending); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        ifa.full = 1'b1;
        ifa.src_valid = 4'hF;
        tick();  // all four captured, no drop
        for (int k = 0; k < 16383; k++) tick();  // 4 drops per cycle
        ifa.src_valid = 4'b0011;
        tick();
        ifa.src_valid = '0;
        n_chk++; if (ifa.drop_cnt !== 16'hFFFE) $display("FAIL sat_preset: got %h want FFFE", ifa.drop_cnt); else n_pass++;
        ifa.src_valid = 4'b0111;
        tick();
        ifa.src_valid = '0;
        n_chk++; if (ifa.drop_cnt !== 16'hFFFF) $display("FAIL sat_limit: got %h want FFFF", ifa.drop_cnt); else n_pass++;
        tick();
        n_chk++; if (ifa.drop_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want FFFF", ifa.drop_cnt); else n_pass++;
        ifa.src_valid = 4'b0001;
        ifa.drop_clr = 1'b1;
        tick();
        ifa.src_valid = '0;
        ifa.drop_clr = 1'b0;
        n_chk++; if (ifa.drop_cnt !== 16'd1) $display("FAIL clr_with_drop: got %h want 0001", ifa.drop_cnt); else n_pass++;
    endtask

    task automatic test_regrant();
        int c;
        do_reset();
        c = cyc;
        exp_a.push_back(24'h22AA01);
        exp_a.push_back(24'h22BB02);
        drive_a(2, 24'h22AA01);
        tick();
        drive_a(2, 24'h22BB02);  // lands on the grant edge of the first word
        tick();
        ifa.src_valid = '0;
        n_chk++; if (ifa.pending[2] !== 1'b1) $display("FAIL regrant_pending: got %b want 1", ifa.pending[2]); else n_pass++;
        for (int k = 0; k < 10; k++) tick();
        n_chk++; if (obs_a_w.size() !== 2) $display("FAIL regrant_push_count: got %0d want 2", obs_a_w.size()); else n_pass++;
        for (int i = 0; i < 2 && obs_a_w.size() > 0 && exp_a.size() > 0; i++) begin
            logic [23:0] o, e;
            int t;
            o = obs_a_w.pop_front(); t = obs_a_t.pop_front(); e = exp_a.pop_front();
            n_chk++; if (o !== e) $display("FAIL regrant_word%0d: got %h want %h", i, o, e); else n_pass++;
            n_chk++; if (t !== c + 2 + 3 * i) $display("FAIL regrant_time%0d: got %0d want %0d", i, t, c + 2 + 3 * i); else n_pass++;
        end
        n_chk++; if (ifa.drop_cnt !== 16'h0) $display("FAIL regrant_drop_cnt: got %h want 0000", ifa.drop_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_push();
        bit seen;
        int n0;
        do_reset();
        ifa.full = 1'b1;
        drive_a(1, 24'h110001); drive_a(2, 24'h220002); drive_a(3, 24'h330003);
        tick();
        ifa.src_valid = '0;
        drive_a(3, 24'h330004);
        tick();
        ifa.src_valid = '0;
        ifa.full = 1'b0;
        n_chk++; if (ifa.drop_cnt !== 16'd1) $display("FAIL mid_pre_drop: got %0d want 1", ifa.drop_cnt); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (ifa.push_s) seen = 1'b1;
        end
        n_chk++; if (!seen) $display("FAIL mid_push_timeout: got no push want one within 20 cycles"); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n0 = obs_a_w.size();
        n_chk++; if (ifa.push_s !== 1'b0) $display("FAIL mid_push_s: got %b want 0", ifa.push_s); else n_pass++;
        n_chk++; if (ifa.pending !== 4'h0) $display("FAIL mid_pending: got %b want 0000", ifa.pending); else n_pass++;
        n_chk++; if (ifa.drop_cnt !== 16'h0) $display("FAIL mid_drop_cnt: got %h want 0000", ifa.drop_cnt); else n_pass++;
        for (int k = 0; k < 12; k++) tick();
        n_chk++; if (obs_a_w.size() !== n0) $display("FAIL mid_extra_push: got %0d want %0d", obs_a_w.size(), n0); else n_pass++;
        n_chk++; if (ifa.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", ifa.busy); else n_pass++;
    endtask

    initial begin
        ifa.src_valid = '0; ifa.src_data = '0; ifa.full = 1'b0; ifa.drop_clr = 1'b0;
        ifb.src_valid = '0; ifb.src_data = '0; ifb.full = 1'b0; ifb.drop_clr = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_overrun();
        test_saturation();
        test_regrant();
        test_reset_mid_push();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/capture_push_arbiter.md
Name: capture_push_arbiter

Overview:
- Shares the single push port of the capture FIFO between independent bus-capture sources: VSYNC frame marker, SCC memory writes, OPLL writes and PSG writes.
- Each source delivers one-cycle pulses that cannot be stalled, because the MSX bus does not wait. The block therefore gives each source a one-deep holding register.
- It arbitrates among pending words and issues the FIFO's two-phase push: a one-cycle push pulse, then one gap cycle.
- It counts words lost to holding-register overrun. It sits between the capture decoders and the FIFO instance, clocked by the 40 MHz system oscillator.

Parameters:
- N_SRC, 4, number of requesters. Index 0 is the VSYNC marker source.
- DW, 24, width of a captured word: 8-bit tag/flags, 8-bit address, 8-bit data.
- CNT_W, 16, width of the drop counter.
- PRIO0, 1, 1 gives source 0 fixed top priority; 0 puts all sources in plain round-robin.

Ports:
- clk  in  1  system clock. Everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  N_SRC  per-source one-cycle capture pulse.
- src_data  in  N_SRC*DW  per-source word; source i occupies bits [i*DW +: DW]. Sampled only when src_valid[i]=1.
- full  in  1  FIFO full flag.
- push_s  out  1  one-cycle FIFO push strobe.
- push_dt  out  DW  word presented with push_s. Held stable through PUSH and GAP.
- pending  out  N_SRC  hold_v flags, one per source.
- busy  out  1  1 when state≠IDLE or any hold_v=1.
- drop_cnt  out  CNT_W  saturating count of dropped words.
- drop_clr  in  1  one-cycle pulse that clears drop_cnt.

Behaviour:
- Reset, applied synchronously at any state: state=IDLE, hold_v=0, push_s=0, push_dt=0, drop_cnt=0, rr_last=N_SRC-1. Any pending or in-flight word is discarded and no push is issued.
- Capture, per source i, each edge:
  - if src_valid[i] and (hold_v[i]=0 or source i is granted at this edge): hold_d[i]<=data, hold_v[i]<=1.
  - else if src_valid[i]: the word is dropped and hold_d[i] is unchanged.
  - else if source i is granted: hold_v[i]<=0.
- Drop counting:
  - drop_cnt increments by the number of drops in the cycle, 0..N_SRC, and saturates at all-ones. There is no wrap.
  - drop_clr has priority: the count loads the number of drops in that same cycle, i.e. 0 plus any new drops.
- FSM, 3 states:
  - IDLE: if full=0 and any hold_v=1, grant source g. At that edge: push_dt<=hold_d[g], push_s<=1, rr_last<=g, go to PUSH. If full=1, no grant; hold registers are kept.
  - PUSH: push_s=1 for exactly this cycle. At the next edge push_s<=0 and the FSM goes to GAP.
  - GAP: push_s=0, then go to IDLE.
  - Maximum throughput is one word per 3 clocks.
- Grant selection:
  - PRIO0=1 and hold_v[0]=1: g=0, and rr_last is unchanged.
  - Otherwise round-robin: the first i with hold_v[i]=1, searching rr_last+1, rr_last+2, ... modulo N_SRC. With PRIO0=1, source 0 is excluded from this search.
- full is sampled only in IDLE at the grant edge. full rising during PUSH or GAP does not cancel the committed push.
- Latency: src_valid at edge E0 with idle FSM, empty hold and no contention. hold_v is set after E0, the grant happens at E1, and push_s is high in the cycle after E1. That is 2 clocks from the valid edge to the push_s edge.
- Outputs push_s, push_dt, pending and drop_cnt are registered. busy is combinational from registers.

Test Plan:
- Single word: reset, then src_valid[2] with data 0x037F12 → push_s high exactly 1 cycle, 2 clocks after the valid edge, push_dt=0x037F12; drop_cnt=0; busy falls in the cycle after GAP.
- Simultaneous requests: valid on all 4 sources in one cycle, data 0x800001 / 0x080011 / 0x030022 / 0x040033, PRIO0=1 → push order src0, src1, src2, src3; pushes 3 clocks apart; drop_cnt=0.
- Round-robin fairness: PRIO0=0, sources 1 and 3 re-pulse immediately after each grant, 10 times each → grants alternate 1,3,1,3,…; each source gets exactly 10 pushes.
- Overrun: src 3 pulsed 3 times while full=1 → first word held, pending[3]=1, drop_cnt=2. Deassert full → exactly one push of the first word.
- Boundary cases:
  - drop_cnt is preset to 0xFFFE, then 3 drops occur → drop_cnt=0xFFFF.
  - drop_clr in the same cycle as 1 drop → drop_cnt=1.
  - Valid on source g at its grant edge → the new word is held, pending[g] stays 1, and a second push follows.
- Reset mid-push: assert reset during PUSH with 2 words pending → push_s=0 in the next cycle, pending=0, drop_cnt=0, no further pushes.
